// File: rtl/nod_pkg.sv
// Shared constants and stage-1 payload for consumers of the 8-bit
// nearest-one detector (NOD).
package nod_pkg;

  localparam int OP_WIDTH_C    = 8;
  localparam int CODE_WIDTH_C  = 9;
  localparam int PROD_WIDTH_C  = 16;
  localparam int SHIFT_WIDTH_C = 4;

  typedef struct packed {
    logic [SHIFT_WIDTH_C-1:0] sh;
    logic [OP_WIDTH_C-1:0]    operand;
    logic                     z;
    logic                     e;
  } s1_t;

endpackage

// File: rtl/onehot_to_bin.sv
// One-hot to binary encoder with a one-hot validity flag.
// Ports: code_i (one-hot in), bin_o (index of set bit), onehot_ok_o.
module onehot_to_bin
  import nod_pkg::*;
#(
  parameter int W  = CODE_WIDTH_C,
  parameter int SW = SHIFT_WIDTH_C
) (
  input  logic [W-1:0]  code_i,
  output logic [SW-1:0] bin_o,
  output logic          onehot_ok_o
);

  always_comb begin
    bin_o = '0;
    for (int i = 0; i < W; i++) begin
      if (code_i[i]) bin_o = bin_o | SW'(i);
    end
  end

  // Exactly one bit set: nonzero and clearing the lowest set bit
  // leaves nothing behind.
  assign onehot_ok_o = (code_i != '0) &&
                       ((code_i & (code_i - W'(1))) == '0);

endmodule

// File: rtl/nod_shift_mult.sv
// Two-stage valid/ready shift multiplier fed by the NOD code.
// Ports: clk_i, rst_ni, valid_i/ready_o, code_i, zero_i, operand_i,
// valid_o/ready_i, product_o, zero_o, err_o.
module nod_shift_mult
  import nod_pkg::*;
#(
  parameter int OP_WIDTH   = OP_WIDTH_C,
  parameter int CODE_WIDTH = CODE_WIDTH_C,
  parameter int PROD_WIDTH = PROD_WIDTH_C
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [CODE_WIDTH-1:0] code_i,
  input  logic                  zero_i,
  input  logic [OP_WIDTH-1:0]   operand_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [PROD_WIDTH-1:0] product_o,
  output logic                  zero_o,
  output logic                  err_o
);

  logic                     s1_valid;
  s1_t                      s1_q;
  s1_t                      s1_d;
  logic [SHIFT_WIDTH_C-1:0] sh;
  logic                     onehot_ok;
  logic                     s2_load;
  logic                     in_xfer;
  logic [PROD_WIDTH-1:0]    prod_d;

  onehot_to_bin #(
    .W  (CODE_WIDTH),
    .SW (SHIFT_WIDTH_C)
  ) u_enc (
    .code_i      (code_i),
    .bin_o       (sh),
    .onehot_ok_o (onehot_ok)
  );

  // S2 frees up in the same cycle it hands its beat downstream.
  assign s2_load = s1_valid & (~valid_o | ready_i);
  assign ready_o = ~s1_valid | s2_load;
  assign in_xfer = valid_i & ready_o;

  always_comb begin
    s1_d         = '0;
    s1_d.sh      = sh;
    s1_d.operand = operand_i;
    s1_d.z       = zero_i;
    s1_d.e       = zero_i ? (code_i != '0) : ~onehot_ok;
  end

  assign prod_d = (s1_q.e | s1_q.z) ? '0 :
                  PROD_WIDTH'(s1_q.operand) << s1_q.sh;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_valid  <= 1'b0;
      valid_o   <= 1'b0;
      product_o <= '0;
      zero_o    <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      s1_valid <= in_xfer | (s1_valid & ~s2_load);
      valid_o  <= s2_load | (valid_o & ~ready_i);
      if (s2_load) begin
        product_o <= prod_d;
        zero_o    <= s1_q.z & ~s1_q.e;
        err_o     <= s1_q.e;
      end
    end
  end

  // Payload of an empty stage is don't-care; valid qualifies it.
  always_ff @(posedge clk_i) begin
    if (in_xfer) s1_q <= s1_d;
  end

endmodule

// File: tb/tb_nod_shift_mult.sv
// Directed and random checks for nod_shift_mult.
// Scoreboard monitors every transfer on the negative edge.
module tb_nod_shift_mult;

  logic        clk;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  logic [8:0]  code_i;
  logic        zero_i;
  logic [7:0]  operand_i;
  logic        valid_o;
  logic        ready_i;
  logic [15:0] product_o;
  logic        zero_o;
  logic        err_o;

  int n_cmp;
  int n_bad;
  logic [17:0] sb[$];

  nod_shift_mult dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .code_i    (code_i),
    .zero_i    (zero_i),
    .operand_i (operand_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .product_o (product_o),
    .zero_o    (zero_o),
    .err_o     (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: {product, zero, err}.
  function automatic logic [17:0] model(input logic [8:0] c,
                                         input logic z,
                                         input logic [7:0] op);
    int cnt;
    int idx;
    logic e;
    logic [31:0] p;
    cnt = 0;
    idx = 0;
    for (int i = 0; i < 9; i++) begin
      if (c[i]) begin
        cnt++;
        idx = i;
      end
    end
    e = z ? (c != 9'd0) : (cnt != 1);
    p = (e | z) ? 32'd0 : ({24'd0, op} << idx);
    return {p[15:0], z & ~e, e};
  endfunction

  always @(negedge clk) begin
    if (!rst_ni) begin
      sb.delete();
    end else begin
      if (valid_o && ready_i) begin
        if (sb.size() == 0) begin
          chk("sb_extra", {14'd0, product_o, zero_o, err_o}, 32'hDEAD);
        end else begin
          chk("sb_beat", {14'd0, product_o, zero_o, err_o},
              {14'd0, sb.pop_front()});
        end
      end
      if (valid_i && ready_o)
        sb.push_back(model(code_i, zero_i, operand_i));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [8:0] c, input logic z,
                      input logic [7:0] op);
    valid_i   = 1'b1;
    code_i    = c;
    zero_i    = z;
    operand_i = op;
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst_ni    = 1'b0;
    valid_i   = 1'b0;
    code_i    = '0;
    zero_i    = 1'b0;
    operand_i = '0;
    ready_i   = 1'b1;
    tick();
    tick();
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_prod", {16'd0, product_o}, 32'd0);
    chk("rst_flags", {30'd0, zero_o, err_o}, 32'd0);
    rst_ni = 1'b1;
    #1;
    chk("rst_ready", {31'd0, ready_o}, 32'd1);

    // Basic latency.
    beat(9'h010, 1'b0, 8'd200);
    tick();
    valid_i = 1'b0;
    chk("lat1_valid", {31'd0, valid_o}, 32'd0);
    tick();
    chk("lat2_valid", {31'd0, valid_o}, 32'd1);
    chk("lat2_prod", {16'd0, product_o}, 32'h0C80);
    chk("lat2_flags", {30'd0, zero_o, err_o}, 32'd0);
    tick();

    // Full throughput, shift extremes.
    beat(9'h100, 1'b0, 8'd255);
    tick();
    beat(9'h001, 1'b0, 8'd255);
    tick();
    valid_i = 1'b0;
    chk("tp_prod0", {16'd0, product_o}, 32'hFF00);
    tick();
    chk("tp_valid1", {31'd0, valid_o}, 32'd1);
    chk("tp_prod1", {16'd0, product_o}, 32'h00FF);
    tick();
    chk("tp_drain", {31'd0, valid_o}, 32'd0);

    // Zero flag and malformed code.
    beat(9'h000, 1'b1, 8'd77);
    tick();
    valid_i = 1'b0;
    tick();
    chk("zero_prod", {16'd0, product_o}, 32'd0);
    chk("zero_flags", {30'd0, zero_o, err_o}, 32'd2);
    beat(9'h005, 1'b0, 8'd9);
    tick();
    valid_i = 1'b0;
    tick();
    chk("err_prod", {16'd0, product_o}, 32'd0);
    chk("err_flags", {30'd0, zero_o, err_o}, 32'd1);
    tick();

    // Backpressure.
    beat(9'h002, 1'b0, 8'd1);
    tick();
    ready_i = 1'b0;
    beat(9'h002, 1'b0, 8'd2);
    tick();
    beat(9'h002, 1'b0, 8'd3);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_ready", {31'd0, ready_o}, 32'd0);
      chk("bp_valid", {31'd0, valid_o}, 32'd1);
      chk("bp_hold", {16'd0, product_o}, 32'd2);
      tick();
    end
    ready_i = 1'b1;
    #1;
    chk("bp_rel_ready", {31'd0, ready_o}, 32'd1);
    chk("bp_out0", {16'd0, product_o}, 32'd2);
    tick();
    beat(9'h002, 1'b0, 8'd4);
    chk("bp_out1", {16'd0, product_o}, 32'd4);
    tick();
    valid_i = 1'b0;
    chk("bp_out2", {16'd0, product_o}, 32'd6);
    tick();
    chk("bp_out3", {16'd0, product_o}, 32'd8);
    tick();
    chk("bp_empty", {31'd0, valid_o}, 32'd0);

    // Reset with both stages full.
    ready_i = 1'b0;
    beat(9'h001, 1'b0, 8'd10);
    tick();
    beat(9'h001, 1'b0, 8'd11);
    tick();
    rst_ni = 1'b0;
    beat(9'h004, 1'b0, 8'd99);
    tick();
    rst_ni  = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    #1;
    chk("mr_valid", {31'd0, valid_o}, 32'd0);
    chk("mr_prod", {16'd0, product_o}, 32'd0);
    chk("mr_ready", {31'd0, ready_o}, 32'd1);
    tick();
    tick();
    chk("mr_ghost", {31'd0, valid_o}, 32'd0);

    // Random traffic; monitor checks every accepted beat.
    for (int k = 0; k < 400; k++) begin
      valid_i   = 1'($urandom_range(0, 1));
      ready_i   = ($urandom_range(0, 3) != 0);
      operand_i = 8'($urandom);
      zero_i    = 1'b0;
      case ($urandom_range(0, 7))
        0: begin
          zero_i = 1'b1;
          code_i = '0;
        end
        1: begin
          zero_i = 1'($urandom_range(0, 1));
          code_i = 9'($urandom);
        end
        default: code_i = 9'd1 << $urandom_range(0, 8);
      endcase
      tick();
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (sb.size() != 0 || valid_o) tick();
    end
    chk("rand_drain", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
